// File: rtl/iic_nco_quad.sv
// rtl/iic_nco_quad.sv - quadrature NCO: phase accumulator, quarter-wave LUT, 2-stage sin/cos pipeline
module iic_nco_quad #(
    parameter int  BW        = 16,
    parameter int  PHASE_W   = 24,
    parameter int  LUT_SIZE  = 6,
    parameter real SINE_AMPL = 0.9
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       en_i,
    input  logic                       data_rd_i,
    input  logic                       sync_i,
    input  logic [PHASE_W-1:0]         freq_i,
    input  logic [LUT_SIZE-1:0]        phase_ofs_i,
    input  logic [3:0]                 atten_i,
    output logic signed [BW-1:0]       sin_o,
    output logic signed [BW-1:0]       cos_o,
    output logic                       valid_o
);
    localparam int  N  = 2 ** LUT_SIZE;
    localparam int  Q  = N / 4 + 1;
    localparam int  AW = LUT_SIZE - 2;
    localparam real PI = 3.14159265358979323846;

    function automatic logic [Q*BW-1:0] build_lut();
        logic [Q*BW-1:0] t;
        real             pk;
        t  = '0;
        pk = SINE_AMPL * (2.0 ** (BW - 1) - 1.0);
        for (int k = 0; k < Q; k++) begin
            t[k*BW +: BW] = BW'($rtoi(pk * $sin(k * 2.0 * PI / N)));
        end
        return t;
    endfunction

    localparam logic [Q*BW-1:0] LUT_ROM = build_lut();

    // Mirror the quarter wave through the quadrant bits of the full-wave index.
    function automatic logic signed [BW-1:0] quad_lookup(input logic [LUT_SIZE-1:0] i);
        logic [1:0]             qd;
        logic [AW-1:0]          a;
        logic [AW:0]            k;
        logic signed [BW-1:0]   mag;
        qd  = i[LUT_SIZE-1 -: 2];
        a   = i[AW-1:0];
        k   = qd[0] ? ((AW+1)'(N / 4) - {1'b0, a}) : {1'b0, a};
        mag = LUT_ROM[k*BW +: BW];
        return qd[1] ? -mag : mag;
    endfunction

    logic [PHASE_W-1:0]    acc;
    logic [PHASE_W-1:0]    acc_nx;
    logic [LUT_SIZE-1:0]   sin_idx;
    logic [LUT_SIZE-1:0]   cos_idx;
    logic signed [BW-1:0]  s1_sin;
    logic signed [BW-1:0]  s1_cos;
    logic                  v1;

    // Stage 1 looks up the post-update phase so a read's sample lands two edges later.
    always_comb begin
        acc_nx = acc;
        if (sync_i) begin
            acc_nx = '0;
        end else if (en_i && data_rd_i) begin
            acc_nx = acc + freq_i;
        end
    end

    assign sin_idx = acc_nx[PHASE_W-1 -: LUT_SIZE] + phase_ofs_i;
    assign cos_idx = sin_idx + LUT_SIZE'(N / 4);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc     <= '0;
            s1_sin  <= '0;
            s1_cos  <= '0;
            v1      <= 1'b0;
            sin_o   <= '0;
            cos_o   <= '0;
            valid_o <= 1'b0;
        end else begin
            acc     <= acc_nx;
            s1_sin  <= en_i ? quad_lookup(sin_idx) : '0;
            s1_cos  <= en_i ? quad_lookup(cos_idx) : '0;
            v1      <= en_i & data_rd_i;
            sin_o   <= s1_sin >>> atten_i;
            cos_o   <= s1_cos >>> atten_i;
            valid_o <= v1;
        end
    end
endmodule

// File: tb/tb_iic_nco_quad.sv
// tb/tb_iic_nco_quad.sv - directed checks of iic_nco_quad against hand-computed samples
module tb_iic_nco_quad;
    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               en = 1'b0;
    logic               rd = 1'b0;
    logic               sync = 1'b0;
    logic [23:0]        freq = '0;
    logic [5:0]         ofs = '0;
    logic [3:0]         atten = '0;
    logic signed [15:0] sin_v;
    logic signed [15:0] cos_v;
    logic               valid;
    int                 total = 0;
    int                 bad = 0;

    localparam logic [23:0] STEP = 24'd262144;

    iic_nco_quad dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .data_rd_i(rd), .sync_i(sync),
        .freq_i(freq), .phase_ofs_i(ofs), .atten_i(atten),
        .sin_o(sin_v), .cos_o(cos_v), .valid_o(valid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check3(input string tag, input int s, input int c, input int v);
        check({tag, "_sin"}, int'(sin_v), s);
        check({tag, "_cos"}, int'(cos_v), c);
        check({tag, "_valid"}, int'(valid), v);
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; rd = 1'b0; sync = 1'b0; ofs = '0; atten = '0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        // reset state
        do_reset();
        check3("reset", 0, 0, 0);

        // quarter, half, three-quarter turn with step 2**18
        en = 1'b1; freq = STEP;
        rd = 1'b1; repeat (16) tick(); rd = 1'b0; tick();
        check3("read16", 29490, 0, 1);
        tick();
        check("read16_valid_drop", int'(valid), 0);
        rd = 1'b1; repeat (16) tick(); rd = 1'b0; tick();
        check3("read32", 0, -29490, 1);
        rd = 1'b1; repeat (16) tick(); rd = 1'b0; tick();
        check3("read48", -29490, 0, 1);

        // negative step wraps to idx 63: sin=-L[1], cos=L[15]
        do_reset();
        en = 1'b1; freq = 24'hFC0000;
        rd = 1'b1; tick(); rd = 1'b0; tick();
        check3("wrap", -2890, 29348, 1);

        // attenuation via phase offset at acc=0
        do_reset();
        en = 1'b1; atten = 4'd2; ofs = 6'd16;
        tick(); tick();
        check3("att2_idx16", 7372, 0, 0);
        ofs = 6'd48; tick(); tick();
        check3("att2_idx48", -7373, 0, 0);
        atten = 4'd15; ofs = 6'd16; tick(); tick();
        check3("att15_idx16", 0, 0, 0);
        ofs = 6'd48; tick(); tick();
        check("att15_idx48_sin", int'(sin_v), -1);
        ofs = 6'd32; tick(); tick();
        check("att15_idx32_cos", int'(cos_v), -1);

        // phase offset of one eighth turn, no read
        atten = 4'd0; ofs = 6'd8; tick(); tick();
        check3("ofs8", 20852, 20852, 0);

        // sync and read together: acc goes to 0, one valid
        do_reset();
        en = 1'b1; freq = STEP;
        rd = 1'b1; repeat (5) tick();
        sync = 1'b1; tick(); sync = 1'b0; rd = 1'b0; tick();
        check3("sync_rd", 0, 29490, 1);
        tick();
        check3("sync_after", 0, 29490, 0);

        // enable drop freezes phase, outputs flush, reads ignored
        do_reset();
        en = 1'b1; freq = STEP;
        rd = 1'b1; repeat (4) tick();
        en = 1'b0; tick(); tick();
        check3("en_low", 0, 0, 0);
        en = 1'b1; tick(); rd = 1'b0; tick();
        check3("resume_idx5", 13901, 26008, 1);

        // reset mid-stream clears outputs on the same edge
        rd = 1'b1; repeat (3) tick();
        rst = 1'b1; tick();
        check3("rst_mid", 0, 0, 0);
        rst = 1'b0; rd = 1'b0; en = 1'b0; tick(); tick();
        check3("post_rst", 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
